// File: rtl/rob.sv
// Reorder buffer.
// Allocates one entry per issued instruction, collects CDB write-backs,
// answers the register file's dependency queries and retires in program order.
// Retirement reports the committed register write, releases stores to the
// load/store buffer, and flushes the whole buffer on a branch mispredict.
//
// Ports:
//   clk_in, rst_in, rdy_in         clock, synchronous active-high reset, global ready
//   issue_*                        one instruction issued per cycle from the decoder
//   issue_rob_entry                entry handed to the instruction issued this cycle
//   rob_full, debug_rob_empty      occupancy flags
//   wb_*                           CDB write-back (value, branch outcome, target)
//   get_rob_entry1/2, ready1/2,    combinational dependency queries
//   value1/2
//   rob_commit, commit_reg_*,      registered one-cycle commit report
//   commit_rob_entry
//   store_commit                   registered pulse releasing the head store
//   rob_clear_up, redirect_pc      registered flush pulse and fetch restart PC
module rob #(
  parameter int ROB_BIT = 4
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               rdy_in,
  input  logic               issue_valid,
  input  logic [1:0]         issue_type,
  input  logic [4:0]         issue_rd,
  input  logic [31:0]        issue_pc,
  input  logic               issue_pred_taken,
  output logic [ROB_BIT-1:0] issue_rob_entry,
  output logic               rob_full,
  output logic               debug_rob_empty,
  input  logic               wb_valid,
  input  logic [ROB_BIT-1:0] wb_entry,
  input  logic [31:0]        wb_value,
  input  logic               wb_taken,
  input  logic [31:0]        wb_target,
  input  logic [ROB_BIT-1:0] get_rob_entry1,
  output logic               ready1,
  output logic [31:0]        value1,
  input  logic [ROB_BIT-1:0] get_rob_entry2,
  output logic               ready2,
  output logic [31:0]        value2,
  output logic               rob_commit,
  output logic [4:0]         commit_reg_id,
  output logic [31:0]        commit_reg_data,
  output logic [ROB_BIT-1:0] commit_rob_entry,
  output logic               store_commit,
  output logic               rob_clear_up,
  output logic [31:0]        redirect_pc
);

  localparam int DEPTH = 1 << ROB_BIT;
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;
  localparam logic [ROB_BIT:0] COUNT_FULL = (ROB_BIT+1)'(DEPTH);

  // Per-entry storage
  logic [DEPTH-1:0] busy_q, busy_d;
  logic [DEPTH-1:0] ready_q, ready_d;
  logic [DEPTH-1:0] pred_q, pred_d;
  logic [DEPTH-1:0] taken_q, taken_d;
  logic [1:0]       type_q   [DEPTH];
  logic [1:0]       type_d   [DEPTH];
  logic [4:0]       rd_q     [DEPTH];
  logic [4:0]       rd_d     [DEPTH];
  logic [31:0]      pc_q     [DEPTH];
  logic [31:0]      pc_d     [DEPTH];
  logic [31:0]      value_q  [DEPTH];
  logic [31:0]      value_d  [DEPTH];
  logic [31:0]      target_q [DEPTH];
  logic [31:0]      target_d [DEPTH];

  logic [ROB_BIT-1:0] head_q, head_d;
  logic [ROB_BIT-1:0] tail_q, tail_d;
  logic [ROB_BIT:0]   count_q, count_d;

  // Registered retirement outputs
  logic               commit_q, commit_d;
  logic [4:0]         cid_q, cid_d;
  logic [31:0]        cdata_q, cdata_d;
  logic [ROB_BIT-1:0] centry_q, centry_d;
  logic               store_q, store_d;
  logic               clear_q, clear_d;
  logic [31:0]        redirect_q, redirect_d;

  logic issue_fire_s;
  logic wb_fire_s;
  logic commit_fire_s;
  logic mispredict_s;

  assign rob_full         = (count_q == COUNT_FULL);
  assign debug_rob_empty  = (count_q == '0);
  assign issue_rob_entry  = tail_q;
  assign rob_commit       = commit_q;
  assign commit_reg_id    = cid_q;
  assign commit_reg_data  = cdata_q;
  assign commit_rob_entry = centry_q;
  assign store_commit     = store_q;
  assign rob_clear_up     = clear_q;
  assign redirect_pc      = redirect_q;

  // Nothing is accepted during the flush cycle; commit uses stored readiness only.
  assign issue_fire_s  = rdy_in && issue_valid && !rob_full && !clear_q;
  assign wb_fire_s     = rdy_in && wb_valid && !clear_q && busy_q[wb_entry];
  assign commit_fire_s = rdy_in && (count_q != '0) && busy_q[head_q] && ready_q[head_q];
  assign mispredict_s  = commit_fire_s && (type_q[head_q] == TYPE_BRANCH) &&
                         (taken_q[head_q] != pred_q[head_q]);

  // Next-state computation for storage, pointers and retirement outputs
  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    pred_d     = pred_q;
    taken_d    = taken_q;
    type_d     = type_q;
    rd_d       = rd_q;
    pc_d       = pc_q;
    value_d    = value_q;
    target_d   = target_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    commit_d   = commit_q;
    cid_d      = cid_q;
    cdata_d    = cdata_q;
    centry_d   = centry_q;
    store_d    = store_q;
    clear_d    = clear_q;
    redirect_d = redirect_q;

    if (wb_fire_s) begin
      ready_d[wb_entry]  = 1'b1;
      value_d[wb_entry]  = wb_value;
      taken_d[wb_entry]  = wb_taken;
      target_d[wb_entry] = wb_target;
    end else begin
      ready_d = ready_d;
    end

    if (issue_fire_s) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      type_d[tail_q]  = issue_type;
      rd_d[tail_q]    = issue_rd;
      pc_d[tail_q]    = issue_pc;
      pred_d[tail_q]  = issue_pred_taken;
      tail_d          = tail_q + ROB_BIT'(1);
    end else begin
      tail_d = tail_q;
    end

    if (commit_fire_s) begin
      busy_d[head_q] = 1'b0;
      head_d         = head_q + ROB_BIT'(1);
    end else begin
      head_d = head_q;
    end

    case ({issue_fire_s, commit_fire_s})
      2'b10:   count_d = count_q + (ROB_BIT+1)'(1);
      2'b01:   count_d = count_q - (ROB_BIT+1)'(1);
      default: count_d = count_q;
    endcase

    // Pulses drop back to zero on every active cycle without a commit;
    // data fields keep the last committed values.
    if (rdy_in) begin
      commit_d = commit_fire_s;
      store_d  = commit_fire_s && (type_q[head_q] == TYPE_STORE);
      clear_d  = mispredict_s;
      if (commit_fire_s) begin
        centry_d = head_q;
        cdata_d  = value_q[head_q];
        cid_d    = (type_q[head_q] == TYPE_STORE) ? 5'd0 : rd_q[head_q];
      end else begin
        centry_d = centry_q;
      end
      if (mispredict_s) begin
        redirect_d = taken_q[head_q] ? target_q[head_q] : (pc_q[head_q] + 32'd4);
      end else begin
        redirect_d = redirect_q;
      end
    end else begin
      commit_d = commit_q;
    end

    // A mispredicted branch empties the buffer, discarding this cycle's issue/wb.
    if (mispredict_s) begin
      busy_d  = '0;
      ready_d = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      count_d = count_d;
    end
  end

  // State registers with synchronous reset; rdy_in low freezes everything.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q     <= '0;
      ready_q    <= '0;
      pred_q     <= '0;
      taken_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        type_q[i]   <= 2'd0;
        rd_q[i]     <= 5'd0;
        pc_q[i]     <= 32'd0;
        value_q[i]  <= 32'd0;
        target_q[i] <= 32'd0;
      end
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      commit_q   <= 1'b0;
      cid_q      <= 5'd0;
      cdata_q    <= 32'd0;
      centry_q   <= '0;
      store_q    <= 1'b0;
      clear_q    <= 1'b0;
      redirect_q <= 32'd0;
    end else begin
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      pred_q     <= pred_d;
      taken_q    <= taken_d;
      type_q     <= type_d;
      rd_q       <= rd_d;
      pc_q       <= pc_d;
      value_q    <= value_d;
      target_q   <= target_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      commit_q   <= commit_d;
      cid_q      <= cid_d;
      cdata_q    <= cdata_d;
      centry_q   <= centry_d;
      store_q    <= store_d;
      clear_q    <= clear_d;
      redirect_q <= redirect_d;
    end
  end

  // Dependency query, source 1 (same-cycle write-back is forwarded)
  always_comb begin
    ready1 = 1'b0;
    value1 = 32'd0;
    if (busy_q[get_rob_entry1]) begin
      if (wb_valid && (wb_entry == get_rob_entry1)) begin
        ready1 = 1'b1;
        value1 = wb_value;
      end else begin
        ready1 = ready_q[get_rob_entry1];
        value1 = value_q[get_rob_entry1];
      end
    end else begin
      ready1 = 1'b0;
    end
  end

  // Dependency query, source 2 (same-cycle write-back is forwarded)
  always_comb begin
    ready2 = 1'b0;
    value2 = 32'd0;
    if (busy_q[get_rob_entry2]) begin
      if (wb_valid && (wb_entry == get_rob_entry2)) begin
        ready2 = 1'b1;
        value2 = wb_value;
      end else begin
        ready2 = ready_q[get_rob_entry2];
        value2 = value_q[get_rob_entry2];
      end
    end else begin
      ready2 = 1'b0;
    end
  end

endmodule

// File: tb/tb_rob.sv
// Self-checking bench for rob: scoreboard of expected commits plus a table of
// dependency-query vectors and hand-written flush / store / freeze sequences.
module tb_rob;

  localparam logic [1:0] T_REG    = 2'd0;
  localparam logic [1:0] T_STORE  = 2'd1;
  localparam logic [1:0] T_BRANCH = 2'd2;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        issue_valid, issue_pred_taken;
  logic [1:0]  issue_type;
  logic [4:0]  issue_rd;
  logic [31:0] issue_pc;
  logic [3:0]  issue_rob_entry;
  logic        rob_full, debug_rob_empty;
  logic        wb_valid, wb_taken;
  logic [3:0]  wb_entry;
  logic [31:0] wb_value, wb_target;
  logic [3:0]  get_rob_entry1, get_rob_entry2;
  logic        ready1, ready2;
  logic [31:0] value1, value2;
  logic        rob_commit, store_commit, rob_clear_up;
  logic [4:0]  commit_reg_id;
  logic [31:0] commit_reg_data, redirect_pc;
  logic [3:0]  commit_rob_entry;

  rob #(.ROB_BIT(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .issue_valid(issue_valid), .issue_type(issue_type), .issue_rd(issue_rd),
    .issue_pc(issue_pc), .issue_pred_taken(issue_pred_taken),
    .issue_rob_entry(issue_rob_entry), .rob_full(rob_full),
    .debug_rob_empty(debug_rob_empty),
    .wb_valid(wb_valid), .wb_entry(wb_entry), .wb_value(wb_value),
    .wb_taken(wb_taken), .wb_target(wb_target),
    .get_rob_entry1(get_rob_entry1), .ready1(ready1), .value1(value1),
    .get_rob_entry2(get_rob_entry2), .ready2(ready2), .value2(value2),
    .rob_commit(rob_commit), .commit_reg_id(commit_reg_id),
    .commit_reg_data(commit_reg_data), .commit_rob_entry(commit_rob_entry),
    .store_commit(store_commit), .rob_clear_up(rob_clear_up),
    .redirect_pc(redirect_pc)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [3:0] entry;
    logic [4:0] id;
    logic       store;
  } sb_t;

  typedef struct {
    logic [3:0]  e1, e2;
    logic        wbv;
    logic [3:0]  wbe;
    logic [31:0] wbval;
    logic        r1;
    logic [31:0] v1;
    logic        cv1;
    logic        r2;
    logic [31:0] v2;
    logic        cv2;
  } qvec_t;

  sb_t         sb[$];
  qvec_t       qv[6];
  int          n_checks = 0;
  int          n_err    = 0;
  logic [3:0]  m_tail;
  logic [1:0]  m_type  [16];
  logic [31:0] m_pc    [16];
  logic        m_pred  [16];
  logic [31:0] m_val   [16];
  logic        m_flush [16];
  logic [31:0] m_redir [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_commit();
    sb_t rec;
    if (rob_commit === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_commit: entry %0d committed, none expected", commit_rob_entry);
      end else begin
        rec = sb.pop_front();
        chk("commit_entry", 32'(commit_rob_entry), 32'(rec.entry));
        chk("commit_reg_id", 32'(commit_reg_id), 32'(rec.id));
        chk("commit_reg_data", commit_reg_data, m_val[rec.entry]);
        chk("store_commit", 32'(store_commit), 32'(rec.store));
        chk("rob_clear_up", 32'(rob_clear_up), 32'(m_flush[rec.entry]));
        if (m_flush[rec.entry]) begin
          chk("redirect_pc", redirect_pc, m_redir[rec.entry]);
          sb.delete();
          m_tail = 4'd0;
        end
      end
    end else begin
      chk("store_without_commit", 32'(store_commit), 32'd0);
      chk("clear_without_commit", 32'(rob_clear_up), 32'd0);
    end
  endtask

  // One clock; commit outputs are scored only for edges where the ROB was active.
  task automatic tick();
    logic active;
    active = rdy_in && !rst_in;
    @(posedge clk_in);
    #1;
    if (active) check_commit();
  endtask

  task automatic clear_in();
    issue_valid = 1'b0;
    wb_valid    = 1'b0;
  endtask

  task automatic do_issue(input logic [1:0] t, input logic [4:0] rd,
                          input logic [31:0] pc, input logic pred, input logic acc);
    sb_t rec;
    chk("issue_rob_entry", 32'(issue_rob_entry), 32'(m_tail));
    issue_valid      = 1'b1;
    issue_type       = t;
    issue_rd         = rd;
    issue_pc         = pc;
    issue_pred_taken = pred;
    if (acc) begin
      rec.entry = m_tail;
      rec.id    = (t == T_STORE) ? 5'd0 : rd;
      rec.store = (t == T_STORE);
      sb.push_back(rec);
      m_type[m_tail]  = t;
      m_pc[m_tail]    = pc;
      m_pred[m_tail]  = pred;
      m_val[m_tail]   = 32'd0;
      m_flush[m_tail] = 1'b0;
      m_tail          = m_tail + 4'd1;
    end
  endtask

  task automatic set_wb(input logic [3:0] e, input logic [31:0] val,
                        input logic tk, input logic [31:0] tgt);
    wb_valid  = 1'b1;
    wb_entry  = e;
    wb_value  = val;
    wb_taken  = tk;
    wb_target = tgt;
    m_val[e]  = val;
    if (m_type[e] == T_BRANCH) begin
      m_flush[e] = (tk != m_pred[e]);
      m_redir[e] = tk ? tgt : (m_pc[e] + 32'd4);
    end else begin
      m_flush[e] = 1'b0;
    end
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    clear_in();
    tick();
    tick();
    rst_in = 1'b0;
    sb.delete();
    m_tail = 4'd0;
  endtask

  initial begin
    rdy_in = 1'b1;
    issue_type = T_REG; issue_rd = 5'd0; issue_pc = 32'd0; issue_pred_taken = 1'b0;
    wb_entry = 4'd0; wb_value = 32'd0; wb_taken = 1'b0; wb_target = 32'd0;
    get_rob_entry1 = 4'd0; get_rob_entry2 = 4'd0;
    for (int i = 0; i < 16; i++) begin
      m_type[i] = T_REG; m_pc[i] = 32'd0; m_pred[i] = 1'b0;
      m_val[i] = 32'd0; m_flush[i] = 1'b0; m_redir[i] = 32'd0;
    end

    //            e1    e2    wbv   wbe   wbval        r1    v1           cv1   r2    v2           cv2
    qv[0] = '{4'd6,  4'd5, 1'b0, 4'd0,  32'h0,  1'b0, 32'h0,  1'b0, 1'b1, 32'h55, 1'b1};
    qv[1] = '{4'd6,  4'd5, 1'b1, 4'd6,  32'h77, 1'b1, 32'h77, 1'b1, 1'b1, 32'h55, 1'b1};
    qv[2] = '{4'd2,  4'd7, 1'b1, 4'd2,  32'h99, 1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0};
    qv[3] = '{4'd7,  4'd6, 1'b1, 4'd6,  32'h66, 1'b0, 32'h0,  1'b0, 1'b1, 32'h66, 1'b1};
    qv[4] = '{4'd15, 4'd3, 1'b1, 4'd15, 32'hF0, 1'b1, 32'hF0, 1'b1, 1'b0, 32'h0,  1'b1};
    qv[5] = '{4'd0,  4'd4, 1'b0, 4'd0,  32'h0,  1'b0, 32'h0,  1'b1, 1'b0, 32'h0,  1'b0};

    // Reset state
    do_reset();
    chk("rst_empty", 32'(debug_rob_empty), 32'd1);
    chk("rst_full", 32'(rob_full), 32'd0);
    chk("rst_commit", 32'(rob_commit), 32'd0);
    chk("rst_store", 32'(store_commit), 32'd0);
    chk("rst_clear", 32'(rob_clear_up), 32'd0);
    chk("rst_reg_id", 32'(commit_reg_id), 32'd0);
    chk("rst_reg_data", commit_reg_data, 32'd0);
    chk("rst_commit_entry", 32'(commit_rob_entry), 32'd0);
    chk("rst_redirect", redirect_pc, 32'd0);

    // Single REG instruction end to end
    do_issue(T_REG, 5'd5, 32'h100, 1'b0, 1'b1);
    tick(); clear_in();
    set_wb(4'd0, 32'h2A, 1'b0, 32'h0);
    tick(); clear_in();
    chk("no_commit_on_wb_edge", 32'(rob_commit), 32'd0);
    tick();
    chk("first_commit_seen", 32'(sb.size()), 32'd0);
    chk("empty_after_commit", 32'(debug_rob_empty), 32'd1);
    tick();
    chk("commit_one_pulse", 32'(rob_commit), 32'd0);

    // Fill, drop while full, out-of-order write-back, in-order retirement
    do_reset();
    for (int i = 0; i < 16; i++) begin
      do_issue(T_REG, 5'(i + 1), 32'h1000 + 32'(4 * i), 1'b0, 1'b1);
      tick();
    end
    clear_in();
    chk("full_after_16", 32'(rob_full), 32'd1);
    do_issue(T_REG, 5'd20, 32'h2000, 1'b0, 1'b0);
    tick(); clear_in();
    chk("tail_after_drop", 32'(issue_rob_entry), 32'd0);
    chk("full_after_drop", 32'(rob_full), 32'd1);
    set_wb(4'd3, 32'h303, 1'b0, 32'h0); tick();
    set_wb(4'd2, 32'h202, 1'b0, 32'h0); tick();
    set_wb(4'd1, 32'h101, 1'b0, 32'h0); tick();
    clear_in(); tick();
    chk("no_commit_head_not_ready", 32'(rob_commit), 32'd0);
    set_wb(4'd0, 32'h0AA, 1'b0, 32'h0); tick(); clear_in();
    for (int i = 0; i < 4; i++) tick();
    chk("four_in_order_commits", 32'(sb.size()), 32'd12);
    tick();
    chk("stop_at_unready_head", 32'(rob_commit), 32'd0);
    chk("not_full_after_commits", 32'(rob_full), 32'd0);

    // Query table (entries 4..15 busy, entry 5 ready with 0x55)
    set_wb(4'd5, 32'h55, 1'b0, 32'h0); tick(); clear_in();
    for (int i = 0; i < 6; i++) begin
      get_rob_entry1 = qv[i].e1;
      get_rob_entry2 = qv[i].e2;
      wb_valid       = qv[i].wbv;
      wb_entry       = qv[i].wbe;
      wb_value       = qv[i].wbval;
      #1;
      chk($sformatf("ready1_v%0d", i), 32'(ready1), 32'(qv[i].r1));
      chk($sformatf("ready2_v%0d", i), 32'(ready2), 32'(qv[i].r2));
      if (qv[i].cv1) chk($sformatf("value1_v%0d", i), value1, qv[i].v1);
      if (qv[i].cv2) chk($sformatf("value2_v%0d", i), value2, qv[i].v2);
    end
    clear_in();

    // Branch mispredict with younger entries behind it
    do_reset();
    do_issue(T_REG,    5'd1, 32'h1F0, 1'b0, 1'b1); tick();
    do_issue(T_BRANCH, 5'd0, 32'h200, 1'b0, 1'b1); tick();
    do_issue(T_REG,    5'd2, 32'h204, 1'b0, 1'b1); tick();
    do_issue(T_REG,    5'd3, 32'h208, 1'b0, 1'b1); tick();
    do_issue(T_REG,    5'd4, 32'h20C, 1'b0, 1'b1); tick();
    clear_in();
    set_wb(4'd2, 32'h22, 1'b0, 32'h0); tick();
    set_wb(4'd3, 32'h33, 1'b0, 32'h0); tick();
    set_wb(4'd1, 32'h204, 1'b1, 32'h400); tick();
    set_wb(4'd0, 32'h10, 1'b0, 32'h0); tick();
    clear_in();
    tick();
    do_issue(T_REG, 5'd9, 32'h210, 1'b0, 1'b0);
    tick(); clear_in();
    chk("flush_pulse", 32'(rob_clear_up), 32'd1);
    chk("flush_redirect", redirect_pc, 32'h400);
    chk("flush_empty", 32'(debug_rob_empty), 32'd1);
    chk("flush_tail", 32'(issue_rob_entry), 32'd0);
    do_issue(T_REG, 5'd11, 32'h400, 1'b0, 1'b0);
    wb_valid = 1'b1; wb_entry = 4'd0; wb_value = 32'hBAD;
    tick(); clear_in();
    chk("flush_one_cycle", 32'(rob_clear_up), 32'd0);
    chk("issue_ignored_in_flush", 32'(issue_rob_entry), 32'd0);
    chk("empty_after_flush", 32'(debug_rob_empty), 32'd1);
    for (int i = 0; i < 3; i++) tick();

    // STORE retirement
    do_issue(T_STORE, 5'd7, 32'h300, 1'b0, 1'b1); tick(); clear_in();
    set_wb(4'd0, 32'hDEAD, 1'b0, 32'h0); tick(); clear_in();
    tick();
    chk("store_retired", 32'(sb.size()), 32'd0);

    // Freeze with a ready head
    do_issue(T_REG, 5'd3, 32'h304, 1'b0, 1'b1); tick(); clear_in();
    set_wb(4'd1, 32'h33, 1'b0, 32'h0); tick(); clear_in();
    rdy_in = 1'b0;
    issue_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("frozen_no_commit", 32'(rob_commit), 32'd0);
      chk("frozen_tail", 32'(issue_rob_entry), 32'd2);
      chk("frozen_data_held", commit_reg_data, 32'hDEAD);
      chk("frozen_not_empty", 32'(debug_rob_empty), 32'd0);
    end
    issue_valid = 1'b0;
    rdy_in = 1'b1;
    tick();
    chk("commit_after_thaw", 32'(sb.size()), 32'd0);
    chk("empty_after_thaw", 32'(debug_rob_empty), 32'd1);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
